// File: rtl/chip_id_reader_if.sv
// Bundle of the chip-ID signals shared by the reader, the hard block and the controller.
interface chip_id_reader_if #(
  parameter int ID_WIDTH = 64
);
  logic                data_valid;
  logic [ID_WIDTH-1:0] chip_id;
  logic                id_shiftnld;
  logic                id_regout;

  // Reader side: drives the result and the hard-block control, takes the serial bit
  modport master (
    output data_valid,
    output chip_id,
    output id_shiftnld,
    input  id_regout
  );

  // Hard block / consumer side
  modport slave (
    input  data_valid,
    input  chip_id,
    input  id_shiftnld,
    output id_regout
  );
endinterface

// File: rtl/chip_id_reader.sv
// One-shot reader for the device unique chip ID.
// After reset it pulses a parallel load into the hard chip-ID block. It then shifts
// ID_WIDTH bits out LSB first and publishes the complete ID together with data_valid.
// The ID is held until the next reset.
module chip_id_reader #(
  parameter int ID_WIDTH = 64
) (
  input  logic              clkin,
  input  logic              reset,
  chip_id_reader_if.master  bus
);

  localparam int CNT_W = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ID_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] chip_id_q, chip_id_d;
  logic                data_valid_q, data_valid_d;
  logic                id_shiftnld;

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      chip_id_q    <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      chip_id_q    <= chip_id_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Next-state and shift/count logic; the serial input is only looked at while shifting
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    chip_id_d    = chip_id_q;
    data_valid_d = data_valid_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sr_d = {bus.id_regout, sr_q[ID_WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the whole word and the flag on the same edge
          chip_id_d    = {bus.id_regout, sr_q[ID_WIDTH-1:1]};
          data_valid_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Hard-block control decoded purely from the registered state
  always_comb begin
    id_shiftnld = 1'b1;
    if (state_q == S_LOAD) id_shiftnld = 1'b0;
  end

  assign bus.id_shiftnld = id_shiftnld;
  assign bus.data_valid  = data_valid_q;
  assign bus.chip_id     = chip_id_q;

endmodule

// File: tb/tb_chip_id_reader.sv
// Directed bench for chip_id_reader: a 64-bit and an 8-bit instance, each fed by a
// behavioural model of the hard chip-ID shift register.
module tb_chip_id_reader;

  logic clk;
  logic rst64, rst8;
  logic [63:0] id64, m64;
  logic [7:0]  id8, m8;
  logic        rand_mode, rand_bit;
  int total, bad;

  chip_id_reader_if #(.ID_WIDTH(64)) if64 ();
  chip_id_reader_if #(.ID_WIDTH(8))  if8 ();

  chip_id_reader #(.ID_WIDTH(64)) dut64 (.clkin(clk), .reset(rst64), .bus(if64.master));
  chip_id_reader #(.ID_WIDTH(8))  dut8  (.clkin(clk), .reset(rst8),  .bus(if8.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard block models: parallel load when shiftnld=0, else shift right, LSB on regout
  always @(posedge clk) begin
    if (!if64.id_shiftnld) m64 <= id64;
    else                   m64 <= {1'b0, m64[63:1]};
    if (!if8.id_shiftnld)  m8  <= id8;
    else                   m8  <= {1'b0, m8[7:1]};
  end

  assign if64.id_regout = rand_mode ? rand_bit : m64[0];
  assign if8.id_regout  = m8[0];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step n edges after reset release, checking the 64-bit reader at each negedge
  task automatic run64(input logic [63:0] exp_id, input int n);
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("shiftnld64_e%0d", e), {63'd0, if64.id_shiftnld}, (e == 1) ? 64'd0 : 64'd1);
      if (e < 66) begin
        check($sformatf("valid64_e%0d", e), {63'd0, if64.data_valid}, 64'd0);
        check($sformatf("id64_e%0d", e), if64.chip_id, 64'd0);
      end else begin
        check($sformatf("valid64_e%0d", e), {63'd0, if64.data_valid}, 64'd1);
        check($sformatf("id64_e%0d", e), if64.chip_id, exp_id);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst64 = 1'b1; rst8 = 1'b1;
    rand_mode = 1'b0; rand_bit = 1'b0;
    id64 = 64'hA5C3_1234_DEAD_BEEF;
    id8  = 8'h3C;
    m64 = '0; m8 = '0;

    repeat (3) @(negedge clk);
    check("rst_valid64", {63'd0, if64.data_valid}, 64'd0);
    check("rst_id64", if64.chip_id, 64'd0);
    check("rst_shiftnld64", {63'd0, if64.id_shiftnld}, 64'd1);
    check("rst_valid8", {63'd0, if8.data_valid}, 64'd0);
    check("rst_id8", {56'd0, if8.chip_id}, 64'd0);
    check("rst_shiftnld8", {63'd0, if8.id_shiftnld}, 64'd1);

    // Basic read of the main pattern
    rst64 = 1'b0;
    run64(64'hA5C3_1234_DEAD_BEEF, 68);

    // Reset while in DONE clears outputs before any clock edge
    #1 rst64 = 1'b1;
    #1;
    check("async_done_valid", {63'd0, if64.data_valid}, 64'd0);
    check("async_done_id", if64.chip_id, 64'd0);
    check("async_done_shiftnld", {63'd0, if64.id_shiftnld}, 64'd1);

    // Bit ordering at both ends
    id64 = 64'h8000_0000_0000_0001;
    repeat (2) @(negedge clk);
    rst64 = 1'b0;
    run64(64'h8000_0000_0000_0001, 66);

    // Reset at edge 30, mid-shift, for 3 cycles, then a full restart
    @(negedge clk) rst64 = 1'b1;
    id64 = 64'h0123_4567_89AB_CDEF;
    repeat (2) @(negedge clk);
    rst64 = 1'b0;
    run64(64'h0123_4567_89AB_CDEF, 29);
    @(posedge clk);
    #1 rst64 = 1'b1;
    #1;
    check("async_shift_valid", {63'd0, if64.data_valid}, 64'd0);
    check("async_shift_id", if64.chip_id, 64'd0);
    check("async_shift_shiftnld", {63'd0, if64.id_shiftnld}, 64'd1);
    repeat (3) @(negedge clk);
    rst64 = 1'b0;
    run64(64'h0123_4567_89AB_CDEF, 66);

    // Reset during LOAD drops the load pulse immediately
    @(negedge clk) rst64 = 1'b1;
    id64 = 64'hFEDC_BA98_7654_3210;
    @(negedge clk) rst64 = 1'b0;
    @(posedge clk);
    #1;
    check("load_pulse", {63'd0, if64.id_shiftnld}, 64'd0);
    rst64 = 1'b1;
    #1;
    check("async_load_shiftnld", {63'd0, if64.id_shiftnld}, 64'd1);
    @(negedge clk) rst64 = 1'b0;
    run64(64'hFEDC_BA98_7654_3210, 66);

    // Serial input is ignored once DONE
    rand_mode = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      rand_bit = 1'($urandom);
      if (c % 100 == 99) begin
        check($sformatf("done_valid_c%0d", c), {63'd0, if64.data_valid}, 64'd1);
        check($sformatf("done_id_c%0d", c), if64.chip_id, 64'hFEDC_BA98_7654_3210);
        check($sformatf("done_shiftnld_c%0d", c), {63'd0, if64.id_shiftnld}, 64'd1);
      end
    end
    rand_mode = 1'b0;

    // 8-bit instance: valid after 10 edges
    @(negedge clk) rst8 = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("shiftnld8_e%0d", e), {63'd0, if8.id_shiftnld}, (e == 1) ? 64'd0 : 64'd1);
      check($sformatf("valid8_e%0d", e), {63'd0, if8.data_valid}, (e < 10) ? 64'd0 : 64'd1);
      check($sformatf("id8_e%0d", e), {56'd0, if8.chip_id}, (e < 10) ? 64'd0 : 64'h3C);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
